// File: rtl/alu_seq.sv
// Registered ALU with flags: single-cycle ADD/SUB/logic/shift ops and an
// iterative shift-add unsigned multiply behind a start/busy/valid handshake.
module alu_seq #(
    parameter int WIDTH = 8,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             valid,
    output logic [WIDTH-1:0] r,
    output logic             carry,
    output logic             overflow,
    output logic             zero,
    output logic             neg
);

    // state | meaning
    // IDLE  | accepts start; single-cycle ops complete here
    // MUL   | shift-add multiply in progress, start ignored
    typedef enum logic {S_IDLE, S_MUL} state_t;

    localparam int              CW       = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]   CNT_INIT = CW'(WIDTH);
    localparam logic [CW-1:0]   CNT_ONE  = CW'(1);
    localparam logic [WIDTH:0]  WIDTH_V  = (WIDTH + 1)'(WIDTH);
    localparam int              M        = WIDTH - 1;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_XOR = 3'b011;
    localparam logic [2:0] OP_OR  = 3'b100;
    localparam logic [2:0] OP_SHL = 3'b101;
    localparam logic [2:0] OP_SHR = 3'b110;
    localparam logic [2:0] OP_MUL = 3'b111;

    state_t               state_q, state_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d, mcand_q, mcand_d;
    logic [WIDTH-1:0]     mplier_q, mplier_d;
    logic [CW-1:0]        cnt_q, cnt_d;

    logic                 load;
    logic [WIDTH-1:0]     res_d;
    logic                 carry_d, ovf_d;

    logic [WIDTH-1:0]     alu_r;
    logic                 alu_c, alu_v;
    logic [WIDTH:0]       sum_add, sum_sub, shl_ext, shr_ext;
    logic                 shamt_big;

    // Shifts are widened by one bit so the last bit shifted out lands in
    // the extra position; amount 0 therefore yields carry 0 naturally.
    always_comb begin
        alu_r     = '0;
        alu_c     = 1'b0;
        alu_v     = 1'b0;
        sum_add   = {1'b0, a} + {1'b0, b};
        sum_sub   = {1'b0, a} + {1'b0, ~b} + (WIDTH + 1)'(1);
        shl_ext   = {1'b0, a} << b[SHW-1:0];
        shr_ext   = {a, 1'b0} >> b[SHW-1:0];
        shamt_big = ({1'b0, b} >= WIDTH_V);
        case (op)
            OP_ADD: begin
                alu_r = sum_add[WIDTH-1:0];
                alu_c = sum_add[WIDTH];
                alu_v = (a[M] == b[M]) && (alu_r[M] != a[M]);
            end
            OP_SUB: begin
                alu_r = sum_sub[WIDTH-1:0];
                alu_c = sum_sub[WIDTH];
                alu_v = (a[M] != b[M]) && (alu_r[M] != a[M]);
            end
            OP_AND: alu_r = a & b;
            OP_XOR: alu_r = a ^ b;
            OP_OR:  alu_r = a | b;
            OP_SHL: if (!shamt_big) {alu_c, alu_r} = shl_ext;
            OP_SHR: if (!shamt_big) {alu_r, alu_c} = shr_ext;
            default: ;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        load     = 1'b0;
        res_d    = alu_r;
        carry_d  = alu_c;
        ovf_d    = alu_v;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (op == OP_MUL) begin
                        state_d  = S_MUL;
                        acc_d    = '0;
                        mcand_d  = {{WIDTH{1'b0}}, a};
                        mplier_d = b;
                        cnt_d    = CNT_INIT;
                    end else begin
                        load = 1'b1;
                    end
                end
            end
            S_MUL: begin
                acc_d    = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q - CNT_ONE;
                if (cnt_q == CNT_ONE) begin
                    state_d = S_IDLE;
                    load    = 1'b1;
                    res_d   = acc_d[WIDTH-1:0];
                    carry_d = |acc_d[2*WIDTH-1:WIDTH];
                    ovf_d   = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            valid    <= 1'b0;
            r        <= '0;
            carry    <= 1'b0;
            overflow <= 1'b0;
            zero     <= 1'b1;
            neg      <= 1'b0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
            valid    <= load;
            if (load) begin
                r        <= res_d;
                carry    <= carry_d;
                overflow <= ovf_d;
                zero     <= (res_d == '0);
                neg      <= res_d[M];
            end
        end
    end

    assign busy = (state_q == S_MUL);

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq (WIDTH = 8): directed vector table, multiply corner
// sequences, and random ops checked against an arithmetic reference model.
module tb_alu_seq;

    logic       clk = 1'b0;
    logic       rst_n, start;
    logic [2:0] op;
    logic [7:0] a, b;
    logic       busy, valid;
    logic [7:0] r;
    logic       carry, overflow, zero, neg;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    alu_seq #(.WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
        .busy(busy), .valid(valid), .r(r), .carry(carry),
        .overflow(overflow), .zero(zero), .neg(neg)
    );

    typedef struct {
        logic [2:0] op;
        logic [7:0] a, b, r;
        logic       c, v, z, n;
    } vec_t;

    vec_t tbl[18];

    // Plain-integer model: values interpreted unsigned and two's-complement.
    function automatic void model(input int o, input int x, input int y,
                                  output int er, output int ec, output int ev);
        int sx, sy, s;
        sx = (x > 127) ? x - 256 : x;
        sy = (y > 127) ? y - 256 : y;
        er = 0; ec = 0; ev = 0;
        case (o)
            0: begin s = x + y; er = s % 256; ec = int'(s > 255);
                     s = sx + sy; ev = int'(s > 127 || s < -128); end
            1: begin er = (x - y + 256) % 256; ec = int'(x >= y);
                     s = sx - sy; ev = int'(s > 127 || s < -128); end
            2: er = x & y;
            3: er = x ^ y;
            4: er = x | y;
            5: if (y > 0 && y < 8) begin er = (x << y) % 256; ec = (x >> (8 - y)) & 1; end
               else if (y == 0) er = x;
            6: if (y > 0 && y < 8) begin er = x >> y; ec = (x >> (y - 1)) & 1; end
               else if (y == 0) er = x;
            default: begin s = x * y; er = s % 256; ec = int'(s > 255); end
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic issue(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y);
        start = 1'b1; op = o; a = x; b = y;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (!valid && n < 20) begin
            tick();
            n++;
        end
    endtask

    task automatic chk_res(input string tag, input logic [7:0] er, input logic ec,
                           input logic ev, input logic ez, input logic en);
        chk({tag, " valid"}, 32'(valid), 32'd1);
        chk({tag, " busy"}, 32'(busy), 32'd0);
        chk({tag, " r"}, 32'(r), 32'(er));
        chk({tag, " carry"}, 32'(carry), 32'(ec));
        chk({tag, " ovf"}, 32'(overflow), 32'(ev));
        chk({tag, " zero"}, 32'(zero), 32'(ez));
        chk({tag, " neg"}, 32'(neg), 32'(en));
    endtask

    initial begin
        int n, pulses, er, ec, ev;
        logic [2:0] o;
        logic [7:0] x, y;

        tbl[0]  = '{3'd0, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1, 1'b0, 1'b1};
        tbl[1]  = '{3'd1, 8'h05, 8'h07, 8'hFE, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[2]  = '{3'd1, 8'h07, 8'h07, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0};
        tbl[3]  = '{3'd5, 8'h81, 8'h01, 8'h02, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[4]  = '{3'd6, 8'h81, 8'h09, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[5]  = '{3'd6, 8'h81, 8'h00, 8'h81, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[6]  = '{3'd0, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0};
        tbl[7]  = '{3'd0, 8'h80, 8'h80, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0};
        tbl[8]  = '{3'd1, 8'h80, 8'h01, 8'h7F, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[9]  = '{3'd2, 8'hF0, 8'h3C, 8'h30, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[10] = '{3'd3, 8'hF0, 8'h3C, 8'hCC, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[11] = '{3'd4, 8'hF0, 8'h0F, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[12] = '{3'd5, 8'h81, 8'h08, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[13] = '{3'd5, 8'h81, 8'h07, 8'h80, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[14] = '{3'd6, 8'h81, 8'h01, 8'h40, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[15] = '{3'd5, 8'h40, 8'h02, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0};
        tbl[16] = '{3'd6, 8'h80, 8'h07, 8'h01, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[17] = '{3'd5, 8'h81, 8'hFF, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0};

        rst_n = 1'b0; start = 1'b0; op = 3'd0; a = 8'h00; b = 8'h00;
        tick();
        tick();
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst valid", 32'(valid), 32'd0);
        chk("rst r", 32'(r), 32'd0);
        chk("rst carry", 32'(carry), 32'd0);
        chk("rst ovf", 32'(overflow), 32'd0);
        chk("rst zero", 32'(zero), 32'd1);
        chk("rst neg", 32'(neg), 32'd0);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 18; i++) begin
            issue(tbl[i].op, tbl[i].a, tbl[i].b);
            chk_res($sformatf("vec%0d", i), tbl[i].r, tbl[i].c, tbl[i].v, tbl[i].z, tbl[i].n);
            tick();
            chk($sformatf("vec%0d pulse end", i), 32'(valid), 32'd0);
            chk($sformatf("vec%0d hold r", i), 32'(r), 32'(tbl[i].r));
        end

        // MUL 0x10*0x11 with an ADD attempted mid-multiply
        issue(3'd7, 8'h10, 8'h11);
        n = 0;
        pulses = 0;
        while (busy && n < 20) begin
            n++;
            if (valid) pulses++;
            if (n == 3) begin start = 1'b1; op = 3'd0; a = 8'h01; b = 8'h01; end
            tick();
            start = 1'b0;
        end
        chk("mul1 busy cycles", 32'(n), 32'd8);
        chk("mul1 early valid", 32'(pulses), 32'd0);
        chk_res("mul1", 8'h10, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        chk("mul1 no extra pulse", 32'(valid), 32'd0);
        chk("mul1 r kept", 32'(r), 32'h10);

        // MUL 0x0F*0x0F then AND accepted in the valid cycle
        issue(3'd7, 8'h0F, 8'h0F);
        wait_valid(n);
        chk("mul2 latency", 32'(n), 32'd8);
        chk_res("mul2", 8'hE1, 1'b0, 1'b0, 1'b0, 1'b1);
        issue(3'd2, 8'hF0, 8'h3C);
        chk_res("and after mul", 8'h30, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();

        // Reset during cycle 4 of a multiply
        issue(3'd7, 8'h03, 8'h05);
        tick();
        tick();
        tick();
        chk("abort busy before rst", 32'(busy), 32'd1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("abort busy", 32'(busy), 32'd0);
        chk("abort valid", 32'(valid), 32'd0);
        chk("abort r", 32'(r), 32'd0);
        chk("abort zero", 32'(zero), 32'd1);
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (valid) pulses++;
        end
        chk("abort no pulse", 32'(pulses), 32'd0);
        issue(3'd0, 8'h03, 8'h04);
        chk_res("post-rst add", 8'h07, 1'b0, 1'b0, 1'b0, 1'b0);

        // Random ops against the model
        for (int i = 0; i < 150; i++) begin
            o = 3'($urandom_range(0, 7));
            x = 8'($urandom);
            y = (o == 3'd5 || o == 3'd6) ? 8'($urandom_range(0, 10)) : 8'($urandom);
            issue(o, x, y);
            if (o == 3'd7) begin
                wait_valid(n);
                chk($sformatf("rnd%0d mul latency", i), 32'(n), 32'd8);
            end
            model(int'(o), int'(x), int'(y), er, ec, ev);
            chk_res($sformatf("rnd%0d op%0d %0h,%0h", i, o, x, y), 8'(er), 1'(ec), 1'(ev),
                    1'(er == 0), 1'((er >> 7) & 1));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, registered successor to the 4-bit combinational ALU.
- Width generalised to WIDTH bits; op set extended to 8 operations, including barrel shifts and an iterative shift-add multiply.
- Adds a start/busy/valid handshake and a flag set (carry, overflow, zero, negative).
- Sits between the register file read ports and the writeback path of the datapath.

Parameters:
- WIDTH, 8, operand and result width in bits (>= 2).
- SHW, $clog2(WIDTH), width of the effective shift-amount field (derived; do not override).

Ports:
- clk  input  1  single system clock; all state changes on its rising edge
- rst_n  input  1  synchronous reset, active low
- start  input  1  request; sampled only when busy = 0
- op  input  3  opcode, sampled with start
- a  input  WIDTH  operand A, sampled with start
- b  input  WIDTH  operand B, sampled with start
- busy  output  1  high while a multiply is in progress
- valid  output  1  one-cycle pulse when r and the flags are updated
- r  output  WIDTH  registered result
- carry  output  1  carry / no-borrow / shifted-out bit / multiply high-half-nonzero
- overflow  output  1  signed overflow (ADD and SUB only)
- zero  output  1  r == 0
- neg  output  1  r[WIDTH-1]

Behaviour:
- Reset (rst_n = 0 at a rising edge):
  - busy = 0, valid = 0, r = 0, carry = 0, overflow = 0, zero = 1, neg = 0.
  - FSM returns to IDLE and the multiply accumulator and counter clear.
  - Reset mid-multiply aborts the operation with no valid pulse.
- Opcodes:
  - 000 ADD: r = a + b.
  - 001 SUB: r = a + ~b + 1.
  - 010 AND, 011 XOR, 100 OR.
  - 101 SHL, 110 SHR (logical).
  - 111 MUL (unsigned).
- FSM states: IDLE, MUL.
- IDLE, start = 1, op != 111:
  - Result computed combinationally and registered at the same edge.
  - valid = 1 for exactly the following cycle; latency 1. busy stays 0.
- IDLE, start = 1, op = 111:
  - Latch a and b, clear the 2*WIDTH accumulator, set the counter to WIDTH, go to MUL. busy = 1 after that edge.
- MUL:
  - Each edge, if the multiplier LSB = 1, add the multiplicand to the accumulator. Then shift the multiplicand left and the multiplier right, and decrement the counter.
  - On the edge where the counter reaches 0:
    - r = accumulator low WIDTH bits.
    - carry = (high WIDTH bits != 0); overflow = 0.
    - valid = 1 and busy = 0 for the next cycle; return to IDLE.
  - Total latency is WIDTH cycles from the start edge.
- start while busy = 1 is ignored, with no queueing. start in the same cycle that valid is high is accepted, because busy = 0.
- Flags:
  - ADD: carry = carry-out of bit WIDTH-1; overflow = (a[MSB] == b[MSB]) && (r[MSB] != a[MSB]).
  - SUB: carry = carry-out of a + ~b + 1 (1 means a >= b unsigned); overflow = (a[MSB] != b[MSB]) && (r[MSB] != a[MSB]).
  - AND, XOR, OR: carry = 0, overflow = 0.
  - Shifts:
    - Amount = b interpreted as unsigned.
    - Amount >= WIDTH: r = 0, carry = 0.
    - Amount 0: r = a, carry = 0.
    - Otherwise carry = last bit shifted out (SHL: a[WIDTH-amt]; SHR: a[amt-1]).
    - overflow = 0.
  - zero and neg are always derived from the new r and updated only when valid is asserted.
- r and all flags hold their values between valid pulses.
- No combinational path from inputs to outputs.

Test Plan:
- WIDTH = 8, ADD a = 0x7F, b = 0x01 -> one cycle later valid = 1, r = 0x80, overflow = 1, neg = 1, carry = 0, zero = 0.
- SUB a = 0x05, b = 0x07 -> r = 0xFE, carry = 0, neg = 1, overflow = 0. Then SUB a = 0x07, b = 0x07 -> r = 0x00, carry = 1, zero = 1.
- SHL a = 0x81, b = 1 -> r = 0x02, carry = 1. SHR a = 0x81, b = 9 -> r = 0x00, carry = 0, zero = 1. SHR a = 0x81, b = 0 -> r = 0x81, carry = 0.
- MUL a = 0x10, b = 0x11 -> busy high for exactly 8 cycles. valid pulses 8 cycles after the start edge with r = 0x10, carry = 1 (product 0x110). A start (ADD) issued mid-multiply is ignored and r is unaffected.
- MUL a = 0x0F, b = 0x0F -> r = 0xE1, carry = 0. An AND issued in the same cycle that valid is high -> accepted, and valid pulses again on the next cycle.
- rst_n = 0 during cycle 4 of a MUL -> busy = 0, valid never pulses, r = 0, zero = 1. The next start after reset operates normally.
